// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between Writeback
// (fixed priority) and a secondary result stream buffered in a small FIFO.
// A secondary entry that loses arbitration for too long forces a one-cycle
// Writeback stall so that the FIFO head gets drained.
module rf_write_arbiter #(
  parameter int unsigned REG_WIDTH     = 32,
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_wr_en,
  input  logic [RF_ADDR_WIDTH-1:0] wb_wr_addr,
  input  logic [REG_WIDTH-1:0]     wb_wr_val,
  output logic                     wb_stall,
  input  logic                     sec_valid,
  output logic                     sec_ready,
  input  logic [RF_ADDR_WIDTH-1:0] sec_addr,
  input  logic [REG_WIDTH-1:0]     sec_val,
  output logic                     sec_pending,
  output logic                     rf_wr_en,
  output logic [RF_ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [REG_WIDTH-1:0]     rf_wr_val
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic                     stall_q, stall_d;
  logic [STV_W-1:0]         starve_q, starve_d;
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     rf_en_q, rf_en_d;
  logic [RF_ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [REG_WIDTH-1:0]     rf_val_q, rf_val_d;

  logic [RF_ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
  logic [REG_WIDTH-1:0]     mem_val_q  [FIFO_DEPTH];

  logic             full, empty, push, pop, wb_win;
  logic [STV_W-1:0] starve_inc;

  // FIFO status and handshake; address 0 completes the handshake but is not stored
  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign sec_ready  = !full;
  assign push       = sec_valid && !full && (sec_addr != '0);
  assign wb_win     = wb_wr_en && (wb_wr_addr != '0);
  assign starve_inc = starve_q + STV_W'(1);

  // Arbitration, starvation tracking and next-state selection
  always_comb begin
    state_d   = state_q;
    stall_d   = 1'b0;
    starve_d  = starve_q;
    rf_en_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_val_d  = rf_val_q;
    pop       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (wb_win) begin
          rf_en_d   = 1'b1;
          rf_addr_d = wb_wr_addr;
          rf_val_d  = wb_wr_val;
          if (!empty) begin
            starve_d = starve_inc;
            if (starve_inc == STV_W'(STARVE_LIMIT)) begin
              stall_d = 1'b1;
              state_d = ST_STALL;
            end
          end else begin
            starve_d = '0;
          end
        end else if (!empty) begin
          pop       = 1'b1;
          rf_en_d   = 1'b1;
          rf_addr_d = mem_addr_q[rd_ptr_q];
          rf_val_d  = mem_val_q[rd_ptr_q];
          starve_d  = '0;
        end else begin
          starve_d = '0;
        end
      end
      ST_STALL: begin
        // Writeback is held this cycle; the FIFO head owns the port
        starve_d = '0;
        state_d  = ST_RUN;
        if (!empty) begin
          pop       = 1'b1;
          rf_en_d   = 1'b1;
          rf_addr_d = mem_addr_q[rd_ptr_q];
          rf_val_d  = mem_val_q[rd_ptr_q];
        end
      end
      default: state_d = ST_RUN;
    endcase
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      stall_q   <= 1'b0;
      starve_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rf_en_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_val_q  <= '0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      starve_q  <= starve_d;
      count_q   <= count_d;
      rf_en_q   <= rf_en_d;
      rf_addr_q <= rf_addr_d;
      rf_val_q  <= rf_val_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // FIFO storage; contents are only meaningful while counted
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= sec_addr;
      mem_val_q[wr_ptr_q]  <= sec_val;
    end
  end

  assign wb_stall    = stall_q;
  assign sec_pending = !empty;
  assign rf_wr_en    = rf_en_q;
  assign rf_wr_addr  = rf_addr_q;
  assign rf_wr_val   = rf_val_q;

endmodule
